// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: waits on variable-latency load responses, buffers them across
// stalls, discards responses of flushed loads and extracts/extends sub-word load data.
module mem_stage_lsu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned REGID_W = 5,
    parameter int unsigned OFF_W   = $clog2(XLEN/8)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_stall,
    input  logic               mem_flush,
    input  logic               in_valid,
    input  logic               in_reg_write,
    input  logic               in_mem_read,
    input  logic               in_mem_unsigned,
    input  logic [1:0]         in_mem_size,
    input  logic [REGID_W-1:0] in_regid,
    input  logic [XLEN-1:0]    in_alu_out,
    input  logic [XLEN-1:0]    in_pc,
    input  logic [XLEN-1:0]    lsu_readdata,
    input  logic               lsu_readdatavalid,
    output logic               mem_busy,
    output logic               out_valid,
    output logic               out_reg_write,
    output logic [REGID_W-1:0] out_regid,
    output logic [XLEN-1:0]    out_writedata,
    output logic [XLEN-1:0]    out_pc
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]         state_q, state_d;
    logic               buf_valid_q, buf_valid_d;
    logic [XLEN-1:0]    buf_data_q, buf_data_d;
    logic               out_valid_q, out_reg_write_q;
    logic [REGID_W-1:0] out_regid_q;
    logic [XLEN-1:0]    out_writedata_q, out_pc_q;

    logic               is_load, stage_run, ld_sign;
    logic [XLEN-1:0]    ld_src, ld_raw, ld_mask, ld_data, wb_data;

    assign is_load   = in_valid & in_mem_read;
    assign mem_busy  = ((state_q == S_IDLE) & is_load & ~lsu_readdatavalid)
                     | ((state_q == S_WAIT) & ~lsu_readdatavalid)
                     | (state_q == S_DRAIN);
    assign stage_run = ~mem_stall & ~mem_busy;

    // Response tracking: flush with a request in flight must drain its response.
    always_comb begin
        state_d     = state_q;
        buf_valid_d = buf_valid_q;
        buf_data_d  = buf_data_q;
        case (state_q)
            S_IDLE: begin
                if (is_load) begin
                    if (mem_flush) begin
                        state_d = lsu_readdatavalid ? S_IDLE : S_DRAIN;
                    end else if (!lsu_readdatavalid) begin
                        state_d = S_WAIT;
                    end else if (mem_stall) begin
                        state_d     = S_HOLD;
                        buf_valid_d = 1'b1;
                        buf_data_d  = lsu_readdata;
                    end
                end
            end
            S_WAIT: begin
                if (mem_flush) begin
                    state_d = lsu_readdatavalid ? S_IDLE : S_DRAIN;
                end else if (lsu_readdatavalid) begin
                    if (mem_stall) begin
                        state_d     = S_HOLD;
                        buf_valid_d = 1'b1;
                        buf_data_d  = lsu_readdata;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HOLD: begin
                if (mem_flush || stage_run) begin
                    state_d     = S_IDLE;
                    buf_valid_d = 1'b0;
                end
            end
            S_DRAIN: begin
                if (lsu_readdatavalid) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Byte-lane extraction and sign/zero extension.
    always_comb begin
        ld_src = buf_valid_q ? buf_data_q : lsu_readdata;
        ld_raw = ld_src >> {in_alu_out[OFF_W-1:0], 3'b000};
        case (in_mem_size)
            2'd0:    begin ld_mask = XLEN'(8'hFF);         ld_sign = ld_raw[7];      end
            2'd1:    begin ld_mask = XLEN'(16'hFFFF);      ld_sign = ld_raw[15];     end
            2'd2:    begin ld_mask = XLEN'(32'hFFFF_FFFF); ld_sign = ld_raw[31];     end
            default: begin ld_mask = '1;                   ld_sign = ld_raw[XLEN-1]; end
        endcase
        ld_data = (ld_raw & ld_mask) | ({XLEN{ld_sign & ~in_mem_unsigned}} & ~ld_mask);
        wb_data = in_mem_read ? ld_data : in_alu_out;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            buf_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_valid_q <= buf_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_data_q <= buf_data_d;
    end

    always_ff @(posedge clk) begin
        if (rst || mem_flush) begin
            out_valid_q     <= 1'b0;
            out_reg_write_q <= 1'b0;
        end else if (stage_run) begin
            out_valid_q     <= in_valid;
            out_reg_write_q <= in_valid & in_reg_write;
        end
    end

    always_ff @(posedge clk) begin
        if (stage_run) begin
            out_regid_q     <= in_regid;
            out_writedata_q <= wb_data;
            out_pc_q        <= in_pc;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_reg_write = out_reg_write_q;
    assign out_regid     = out_regid_q;
    assign out_writedata = out_writedata_q;
    assign out_pc        = out_pc_q;

endmodule
